// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding and
// peripheral control/status register bit positions.
package uart_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_DATA  = 3'd1,
    ST_WR_GO    = 3'd2,
    ST_WR_CLR   = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_POLL     = 3'd5
  } state_e;

  localparam int CTRL_RX_ACK_BIT  = 0;
  localparam int CTRL_LED_BIT     = 2;
  localparam int CTRL_TX_WR_BIT   = 3;
  localparam int STAT_TX_BUSY_BIT = 9;

  // rx_ack is never asserted by this block; only tx_wr and led are driven.
  function automatic logic [7:0] ctrl_word(input logic tx_wr, input logic led);
    logic [7:0] w;
    w                  = '0;
    w[CTRL_RX_ACK_BIT] = 1'b0;
    w[CTRL_LED_BIT]    = led;
    w[CTRL_TX_WR_BIT]  = tx_wr;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arb2.sv
// Two-way round-robin arbiter with a one-hot grant; the requester that did
// not win last time takes a tie. After reset req0 takes a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic prio_q;  // 1: req1 wins the next tie

  always_comb begin
    gnt_o = req_i;
    if (&req_i) gnt_o = prio_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (advance_i) begin
      prio_q <= gnt_o[0];
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates two byte requesters onto a UART peripheral: data write, go/clear
// control writes, settle delay, then tx_busy polling with a timeout.
//
// state    | meaning
// IDLE     | waiting for a requester; grant and ready happen here
// WR_DATA  | write latched byte to TX_ADDR
// WR_GO    | write ctrl with tx_wr=1
// WR_CLR   | write ctrl with tx_wr=0
// SETTLE   | bus quiet for SETTLE_CYC cycles
// POLL     | read ctrl/status until tx_busy clears or poll budget runs out
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter logic [4:0] TX_ADDR     = 5'h08,
  parameter logic [4:0] CTRL_ADDR   = 5'h10,
  parameter int         SETTLE_CYC  = 2,
  parameter int         TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [7:0]  req0_data,
  input  logic [7:0]  req1_data,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic        led_cfg,
  output logic        bus_cs,
  output logic        bus_wr,
  output logic [4:0]  bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic        grant_id,
  output logic        timeout_err
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [TW-1:0] POLL_LIMIT  = TW'(TIMEOUT_CYC);

  state_e        state_q;
  logic          cs_q, wr_q, busy_q, grant_id_q, timeout_q;
  logic [4:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [SW-1:0] settle_q;
  logic [TW-1:0] poll_q, poll_d;
  logic [1:0]    gnt;
  logic          grant_fire;
  logic [7:0]    win_data;
  logic          unused_rdata;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     ({req1_valid, req0_valid}),
    .advance_i (grant_fire),
    .gnt_o     (gnt)
  );

  assign grant_fire = (state_q == ST_IDLE) && (|gnt);
  assign req0_ready = grant_fire & gnt[0];
  assign req1_ready = grant_fire & gnt[1];
  assign win_data   = gnt[1] ? req1_data : req0_data;
  assign poll_d     = poll_q + TW'(1);

  assign unused_rdata = ^{bus_rdata[31:STAT_TX_BUSY_BIT+1], bus_rdata[STAT_TX_BUSY_BIT-1:0]};

  // Bus outputs are registered for the state being entered, so they line up
  // with state_q during the access cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      grant_id_q <= 1'b0;
      timeout_q  <= 1'b0;
      settle_q   <= '0;
      poll_q     <= '0;
    end else begin
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant_fire) begin
            state_q    <= ST_WR_DATA;
            busy_q     <= 1'b1;
            grant_id_q <= gnt[1];
            cs_q       <= 1'b1;
            wr_q       <= 1'b1;
            addr_q     <= TX_ADDR;
            wdata_q    <= win_data;
          end
        end
        ST_WR_DATA: begin
          state_q <= ST_WR_GO;
          cs_q    <= 1'b1;
          wr_q    <= 1'b1;
          addr_q  <= CTRL_ADDR;
          wdata_q <= ctrl_word(1'b1, led_cfg);
        end
        ST_WR_GO: begin
          state_q <= ST_WR_CLR;
          cs_q    <= 1'b1;
          wr_q    <= 1'b1;
          addr_q  <= CTRL_ADDR;
          wdata_q <= ctrl_word(1'b0, led_cfg);
        end
        ST_WR_CLR: begin
          poll_q   <= '0;
          settle_q <= SETTLE_LOAD;
          if (SETTLE_CYC == 0) begin
            state_q <= ST_POLL;
            cs_q    <= 1'b1;
            addr_q  <= CTRL_ADDR;
          end else begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            state_q <= ST_POLL;
            cs_q    <= 1'b1;
            addr_q  <= CTRL_ADDR;
          end else begin
            settle_q <= settle_q - SW'(1);
          end
        end
        ST_POLL: begin
          poll_q <= poll_d;
          if (!bus_rdata[STAT_TX_BUSY_BIT]) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (poll_d == POLL_LIMIT) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            cs_q   <= 1'b1;
            addr_q <= CTRL_ADDR;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_cs      = cs_q;
  assign bus_wr      = wr_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: a driver predicts grants, bus writes
// and per-byte poll counts; a negedge monitor pops and compares.
module tb_uart_tx_scheduler;

  localparam int         S   = 2;
  localparam int         TMO = 12;
  localparam logic [4:0] TXA = 5'h08;
  localparam logic [4:0] CTA = 5'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        led_cfg = 1'b0;
  logic        bus_cs, bus_wr;
  logic [4:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic [31:0] bus_rdata;
  logic        busy, grant_id, timeout_err;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .TX_ADDR(TXA), .CTRL_ADDR(CTA), .SETTLE_CYC(S), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .led_cfg(led_cfg),
    .bus_cs(bus_cs), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  // Peripheral: reports tx_busy for the first n_busy polls of each byte.
  int        poll_seen = 0;
  int        n_busy = 0;
  bit [31:0] junk = '0;
  always @(posedge clk) begin
    if (rst || req0_ready || req1_ready) poll_seen <= 0;
    else if (bus_cs && !bus_wr)          poll_seen <= poll_seen + 1;
    junk <= $urandom;
  end
  assign bus_rdata = {junk[31:10], (poll_seen < n_busy), junk[8:0]};

  typedef struct { logic [4:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int polls; int lat; bit to; } end_t;
  wr_t  wr_q[$];
  int   gnt_q[$];
  end_t end_q[$];

  bit prio = 1'b0;     // 1: req1 takes the next tie
  bit exp_to = 1'b0;
  int drv_to = 0;
  bit done = 1'b0;

  function automatic int exp_polls(input int n);
    return (n >= TMO) ? TMO : n + 1;
  endfunction

  task automatic push_txn(input logic [1:0] pat, input logic [7:0] d0, input logic [7:0] d1,
                          input bit led, input int n, input bit with_end);
    int w, p;
    w    = (pat == 2'b11) ? int'(prio) : (pat[1] ? 1 : 0);
    prio = (w == 0);
    gnt_q.push_back(w);
    wr_q.push_back('{TXA, (w == 1) ? d1 : d0});
    wr_q.push_back('{CTA, {4'b0000, 1'b1, led, 2'b00}});
    wr_q.push_back('{CTA, {5'b00000, led, 2'b00}});
    p = exp_polls(n);
    if (n >= TMO) exp_to = 1'b1;
    if (with_end) end_q.push_back('{p, 4 + S + p - 1, exp_to});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    drv_to++;
  endtask

  task automatic wait_hs();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) return;
    end
    drv_to++;
  endtask

  task automatic do_txn(input logic [1:0] pat, input logic [7:0] d0, input logic [7:0] d1,
                        input bit led, input int n);
    int k;
    wait_idle();
    @(posedge clk); #1;
    led_cfg = led; n_busy = n;
    req0_data = d0; req1_data = d1;
    req0_valid = pat[0]; req1_valid = pat[1];
    push_txn(pat, d0, d1, led, n, 1'b1);
    wait_hs();
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    // Requesters wiggle while the byte is in flight; none may be accepted.
    k = 3 + exp_polls(n);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_data  = 8'($urandom);
      req1_data  = 8'($urandom);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic burst4();
    wait_idle();
    @(posedge clk); #1;
    led_cfg = 1'b0; n_busy = 0;
    req0_data = 8'hAA; req1_data = 8'h55;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) push_txn(2'b11, 8'hAA, 8'h55, 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) wait_hs();
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic reset_in_settle();
    wait_idle();
    @(posedge clk); #1;
    led_cfg = 1'b1; n_busy = 3;
    req0_data = 8'h3C; req0_valid = 1'b1;
    push_txn(2'b01, 8'h3C, 8'h00, 1'b1, 3, 1'b0);
    wait_hs();
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; prio = 1'b0; exp_to = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Driver
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    burst4();
    do_txn(2'b01, 8'h41, 8'h00, 1'b1, 0);
    do_txn(2'b10, 8'h7E, 8'h99, 1'b0, 10);
    do_txn(2'b01, 8'h12, 8'h34, 1'b1, TMO - 1);
    do_txn(2'b11, 8'hC3, 8'h5A, 1'b0, TMO + 3);
    do_txn(2'b01, 8'hE1, 8'h00, 1'b1, 0);
    reset_in_settle();
    do_txn(2'b10, 8'h00, 8'hB7, 1'b0, 0);
    for (int t = 0; t < 30; t++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO - 1, TMO + 2))
                                      : int'($urandom_range(0, 4));
      do_txn(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), n);
    end
    wait_idle();
    repeat (10) @(posedge clk);
    done = 1'b1;
  end

  // Monitor / scoreboard
  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int  cyc = 0, t0 = 0, poll_cnt = 0, seen_to = 0, last_id = 0, id;
    bit  prev_busy = 1'b0, rst_seen = 1'b0;
    wr_t w;
    end_t e;
    forever begin
      @(negedge clk);
      if (drv_to != seen_to) begin
        n_cmp++; n_fail++;
        $display("FAIL driver_wait: wait budget expired, count %0d", drv_to);
        seen_to = drv_to;
      end
      if (rst) begin
        if (rst_seen) begin
          chk("rst_bus", 32'({bus_cs, bus_wr, bus_addr, bus_wdata}), 32'd0);
          chk("rst_busy", 32'(busy), 32'd0);
          chk("rst_grant_id", 32'(grant_id), 32'd0);
          chk("rst_timeout", 32'(timeout_err), 32'd0);
          chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        end
        rst_seen  = 1'b1;
        prev_busy = 1'b0;
      end else begin
        rst_seen = 1'b0;
        if (bus_cs && bus_wr) begin
          if (wr_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL bus_write: unexpected write %0h@%0h", bus_wdata, bus_addr);
          end else begin
            w = wr_q.pop_front();
            chk("wr_addr", 32'(bus_addr), 32'(w.addr));
            chk("wr_data", 32'(bus_wdata), 32'(w.data));
          end
        end else if (bus_cs) begin
          poll_cnt++;
          chk("poll_addr", 32'(bus_addr), 32'(CTA));
          chk("poll_wdata", 32'(bus_wdata), 32'd0);
        end else begin
          chk("idle_bus", 32'({bus_wr, bus_addr, bus_wdata}), 32'd0);
        end
        if (prev_busy && !busy) begin
          if (end_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL byte_end: unexpected end of byte");
          end else begin
            e = end_q.pop_front();
            chk("poll_count", 32'(poll_cnt), 32'(e.polls));
            chk("latency", 32'(cyc - t0 - 1), 32'(e.lat));
            chk("timeout_err", 32'(timeout_err), 32'(e.to));
          end
        end
        if (!prev_busy && busy) chk("grant_id", 32'(grant_id), 32'(last_id));
        if (req0_ready || req1_ready) begin
          chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
          chk("ready_in_idle", 32'(busy), 32'd0);
          if (gnt_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL ready: unexpected ready r0=%0b r1=%0b", req0_ready, req1_ready);
          end else begin
            id = gnt_q.pop_front();
            chk("grant_winner", 32'(req1_ready), 32'(id));
            last_id = id;
          end
          t0 = cyc;
          poll_cnt = 0;
        end
        prev_busy = busy;
      end
      cyc++;
      if (done) begin
        chk("left_grants", 32'(gnt_q.size()), 32'd0);
        chk("left_writes", 32'(wr_q.size()), 32'd0);
        chk("left_ends", 32'(end_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
